// File: rtl/float_round_pipe.sv
`default_nettype none
// ============================================================================
// Module      : float_round_pipe
// Description : Two-stage valid/ready rounding stage. It applies one of five
//               rounding modes to a normalised mantissa using its guard and
//               sticky bits. A mantissa carry-out renormalises the result.
//               The stage flags inexact results and exponent overflow to
//               infinity.
// Revision    : 1.0 - initial release
// ============================================================================
module float_round_pipe #(
  parameter int MANT_W = 24,
  parameter int EXP_W  = 8
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [MANT_W-1:0] in_mant,
  input  logic [EXP_W-1:0]  in_exp,
  input  logic              in_sign,
  input  logic              in_R,
  input  logic              in_S,
  input  logic [2:0]        in_mode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [MANT_W-1:0] out_mant,
  output logic [EXP_W-1:0]  out_exp,
  output logic              out_sign,
  output logic              out_inexact,
  output logic              out_overflow
);

  localparam logic [EXP_W-1:0]  c_exp_ones = '1;
  localparam logic [MANT_W-1:0] c_mant_msb = {1'b1, {(MANT_W-1){1'b0}}};

  localparam logic [2:0] c_mode_rtz = 3'd1;
  localparam logic [2:0] c_mode_rdn = 3'd2;
  localparam logic [2:0] c_mode_rup = 3'd3;
  localparam logic [2:0] c_mode_rmm = 3'd4;

  // stage 1 state
  logic              r_v1;
  logic [MANT_W:0]   r_sum;
  logic [EXP_W-1:0]  r_exp;
  logic              r_sign;
  logic              r_inexact;
  logic              r_special;

  // handshake and datapath wires
  logic              w_en1;
  logic              w_en2;
  logic              w_inc;
  logic              w_special;
  logic [MANT_W:0]   w_sum;
  logic [EXP_W-1:0]  w_exp_inc;
  logic              w_carry;
  logic              w_ovf;
  logic [MANT_W-1:0] w_mant2;
  logic [EXP_W-1:0]  w_exp2;

  // A stage may load when it is empty or when its content moves on this cycle.
  assign w_en2    = !out_valid | out_ready;
  assign w_en1    = !r_v1 | w_en2;
  assign in_ready = w_en1;

  // Increment decision for the selected rounding mode; unused codes fall back to RNE.
  always_comb begin
    w_inc = in_R & (in_S | in_mant[0]);
    case (in_mode)
      c_mode_rtz: w_inc = 1'b0;
      c_mode_rdn: w_inc = in_sign & (in_R | in_S);
      c_mode_rup: w_inc = !in_sign & (in_R | in_S);
      c_mode_rmm: w_inc = in_R;
      default:    w_inc = in_R & (in_S | in_mant[0]);
    endcase
  end

  // Inf/NaN operands get no increment, so r_sum carries the untouched mantissa.
  assign w_special = (in_exp == c_exp_ones);
  assign w_sum     = {1'b0, in_mant} + {{MANT_W{1'b0}}, (w_inc & !w_special)};

  // Stage 1: register the incremented mantissa and the per-beat side information.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_v1      <= 1'b0;
      r_sum     <= '0;
      r_exp     <= '0;
      r_sign    <= 1'b0;
      r_inexact <= 1'b0;
      r_special <= 1'b0;
    end else if (w_en1) begin
      r_v1 <= in_valid;
      if (in_valid) begin
        r_sum     <= w_sum;
        r_exp     <= in_exp;
        r_sign    <= in_sign;
        r_inexact <= in_R | in_S;
        r_special <= w_special;
      end
    end
  end

  // Renormalise on carry-out; a carry into the all-ones exponent becomes infinity.
  assign w_carry   = r_sum[MANT_W];
  assign w_exp_inc = r_exp + 1'b1;
  assign w_ovf     = !r_special & w_carry & (w_exp_inc == c_exp_ones);

  // Select the final mantissa and exponent for stage 2.
  always_comb begin
    w_mant2 = r_sum[MANT_W-1:0];
    w_exp2  = r_exp;
    if (!r_special && w_carry) begin
      w_mant2 = w_ovf ? '0 : c_mant_msb;
      w_exp2  = w_exp_inc;
    end
  end

  // Stage 2: output registers, held stable while downstream stalls.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      out_valid    <= 1'b0;
      out_mant     <= '0;
      out_exp      <= '0;
      out_sign     <= 1'b0;
      out_inexact  <= 1'b0;
      out_overflow <= 1'b0;
    end else if (w_en2) begin
      out_valid <= r_v1;
      if (r_v1) begin
        out_mant     <= w_mant2;
        out_exp      <= w_exp2;
        out_sign     <= r_sign;
        out_inexact  <= r_inexact & !r_special;
        out_overflow <= w_ovf;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_float_round_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_float_round_pipe
// Description : Scoreboard bench for float_round_pipe. It drives directed and
//               random beats and queues the expected results. A monitor
//               compares each beat that leaves the pipe.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_float_round_pipe;

  localparam int MW = 24;
  localparam int EW = 8;

  typedef struct {
    logic [MW-1:0] mant;
    logic [EW-1:0] exp;
    logic          sign;
    logic          inexact;
    logic          overflow;
    int            acc_cyc;
    bit            chk_lat;
  } exp_t;

  logic          Clock;
  logic          Reset;
  logic          in_valid;
  logic          in_ready;
  logic [MW-1:0] in_mant;
  logic [EW-1:0] in_exp;
  logic          in_sign;
  logic          in_R;
  logic          in_S;
  logic [2:0]    in_mode;
  logic          out_valid;
  logic          out_ready;
  logic [MW-1:0] out_mant;
  logic [EW-1:0] out_exp;
  logic          out_sign;
  logic          out_inexact;
  logic          out_overflow;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   stall_left = 0;
  int   stall_acc = 0;
  int   outs = 0;
  int   last_out_cyc = 0;
  exp_t exq[$];

  float_round_pipe #(.MANT_W(MW), .EXP_W(EW)) dut (
    .Clock(Clock), .Reset(Reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_mant(in_mant), .in_exp(in_exp), .in_sign(in_sign),
    .in_R(in_R), .in_S(in_S), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_mant(out_mant), .out_exp(out_exp), .out_sign(out_sign),
    .out_inexact(out_inexact), .out_overflow(out_overflow)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  always @(posedge Clock) cyc <= cyc + 1;

  // Reference: round the mantissa as an integer value, then renormalise.
  function automatic exp_t model(input logic [MW-1:0] m, input logic [EW-1:0] e,
                                 input logic s, input logic r, input logic st,
                                 input logic [2:0] md);
    exp_t   x;
    longint v;
    bit     up;
    bit     tail;
    tail = r || st;
    x.sign = s; x.chk_lat = 0; x.acc_cyc = 0; x.overflow = 0;
    if (e == {EW{1'b1}}) begin
      x.mant = m; x.exp = e; x.inexact = 0;
      return x;
    end
    if (md == 1)      up = 0;
    else if (md == 2) up = s && tail;
    else if (md == 3) up = !s && tail;
    else if (md == 4) up = r;
    else              up = r && (st || (m % 2 == 1));
    v = longint'(m) + (up ? 1 : 0);
    x.inexact = tail;
    x.exp = e;
    if (v >= (64'd1 << MW)) begin
      v = v / 2;
      x.exp = e + 1;
      if (x.exp == {EW{1'b1}}) begin
        v = 0;
        x.overflow = 1;
      end
    end
    x.mant = v[MW-1:0];
    return x;
  endfunction

  function automatic exp_t mk(input logic [MW-1:0] m, input logic [EW-1:0] e,
                              input logic s, input logic inx, input logic ovf,
                              input bit lat);
    exp_t x;
    x.mant = m; x.exp = e; x.sign = s; x.inexact = inx; x.overflow = ovf;
    x.acc_cyc = 0; x.chk_lat = lat;
    return x;
  endfunction

  // Monitor: compare each beat the DUT hands downstream; check hold while stalled.
  logic          held = 0;
  logic [MW+EW+2:0] snap;
  always @(negedge Clock) begin
    #2;
    if (Reset && out_valid) begin
      if (held) begin
        checks++;
        if ({out_mant, out_exp, out_sign, out_inexact, out_overflow} !== snap) begin
          errors++;
          $display("FAIL stall_hold: got %h want %h", {out_mant, out_exp, out_sign, out_inexact, out_overflow}, snap);
        end
      end
      if (out_ready) begin
        held = 0;
        outs++;
        last_out_cyc = cyc;
        checks++;
        if (exq.size() == 0) begin
          errors++;
          $display("FAIL unexpected_beat: got mant=%h exp=%h with empty scoreboard", out_mant, out_exp);
        end else begin
          exp_t x;
          x = exq.pop_front();
          if (out_mant !== x.mant || out_exp !== x.exp || out_sign !== x.sign ||
              out_inexact !== x.inexact || out_overflow !== x.overflow) begin
            errors++;
            $display("FAIL result: got mant=%h exp=%h s=%b inx=%b ovf=%b want mant=%h exp=%h s=%b inx=%b ovf=%b",
                     out_mant, out_exp, out_sign, out_inexact, out_overflow,
                     x.mant, x.exp, x.sign, x.inexact, x.overflow);
          end
          if (x.chk_lat) begin
            checks++;
            if (cyc - x.acc_cyc != 2) begin
              errors++;
              $display("FAIL latency: got %0d want 2", cyc - x.acc_cyc);
            end
          end
        end
      end else begin
        held = 1;
        snap = {out_mant, out_exp, out_sign, out_inexact, out_overflow};
      end
    end else begin
      held = 0;
    end
  end

  task automatic step_ready();
    out_ready = (stall_left == 0);
    if (stall_left > 0) stall_left--;
  endtask

  task automatic send(input logic [MW-1:0] m, input logic [EW-1:0] e, input logic s,
                      input logic r, input logic st, input logic [2:0] md,
                      input exp_t ex, output int acc);
    int waitc;
    exp_t x;
    waitc = 0;
    acc = -1;
    x = ex;
    forever begin
      @(negedge Clock);
      step_ready();
      in_valid = 1; in_mant = m; in_exp = e; in_sign = s; in_R = r; in_S = st; in_mode = md;
      #1;
      if (in_ready) begin
        x.acc_cyc = cyc;
        acc = cyc;
        if (!out_ready) stall_acc++;
        exq.push_back(x);
        break;
      end
      waitc++;
      if (waitc > 50) begin
        checks++; errors++;
        $display("FAIL send_timeout: in_ready low for %0d cycles, want accept", waitc);
        break;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge Clock);
      step_ready();
      in_valid = 0;
      #1;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exq.size() != 0 && n < 200) begin
      idle(1);
      n++;
    end
    checks++;
    if (exq.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d beats outstanding, want 0", exq.size());
    end
  endtask

  task automatic chk(input string name, input longint got, input longint want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  // Sends one beat whose expected result comes from the reference model.
  task automatic send_m(input logic [MW-1:0] m, input logic [EW-1:0] e, input logic s,
                        input logic r, input logic st, input logic [2:0] md, output int acc);
    send(m, e, s, r, st, md, model(m, e, s, r, st, md), acc);
  endtask

  initial begin
    int a;
    int first;
    int outs0;
    logic [MW-1:0] m;
    logic [EW-1:0] e;

    Reset = 0; in_valid = 0; out_ready = 1;
    in_mant = '0; in_exp = '0; in_sign = 0; in_R = 0; in_S = 0; in_mode = '0;
    #12;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_fields", {out_mant, out_exp, out_sign, out_inexact, out_overflow}, 0);
    @(negedge Clock); Reset = 1;
    #1;
    chk("reset_in_ready", in_ready, 1);

    // RNE ties with latency check
    send(24'h800001, 8'h40, 0, 1, 0, 3'd0, mk(24'h800002, 8'h40, 0, 1, 0, 1), a);
    idle(3);
    send(24'h800002, 8'h40, 0, 1, 0, 3'd0, mk(24'h800002, 8'h40, 0, 1, 0, 1), a);
    idle(3);

    // Directed modes, negative then positive sign
    send(24'h800000, 8'h40, 1, 0, 1, 3'd2, mk(24'h800001, 8'h40, 1, 1, 0, 0), a);
    send(24'h800000, 8'h40, 1, 0, 1, 3'd3, mk(24'h800000, 8'h40, 1, 1, 0, 0), a);
    send(24'h800000, 8'h40, 1, 0, 1, 3'd1, mk(24'h800000, 8'h40, 1, 1, 0, 0), a);
    send(24'h800000, 8'h40, 1, 0, 1, 3'd0, mk(24'h800000, 8'h40, 1, 1, 0, 0), a);
    send(24'h800000, 8'h40, 1, 0, 1, 3'd4, mk(24'h800000, 8'h40, 1, 1, 0, 0), a);
    send(24'h800000, 8'h40, 0, 0, 1, 3'd3, mk(24'h800001, 8'h40, 0, 1, 0, 0), a);
    send(24'h800000, 8'h40, 0, 0, 1, 3'd2, mk(24'h800000, 8'h40, 0, 1, 0, 0), a);
    send(24'h800001, 8'h40, 0, 1, 0, 3'd7, mk(24'h800002, 8'h40, 0, 1, 0, 0), a);

    // Carry renormalisation, overflow to infinity, special passthrough
    send(24'hFFFFFF, 8'h10, 0, 1, 0, 3'd4, mk(24'h800000, 8'h11, 0, 1, 0, 0), a);
    send(24'hFFFFFF, 8'hFE, 1, 1, 0, 3'd4, mk(24'h000000, 8'hFF, 1, 1, 1, 0), a);
    send(24'hFFFFFF, 8'hFF, 0, 1, 0, 3'd4, mk(24'hFFFFFF, 8'hFF, 0, 0, 0, 0), a);
    // Zero input rounds arithmetically
    send(24'h000000, 8'h00, 0, 1, 1, 3'd0, mk(24'h000001, 8'h00, 0, 1, 0, 0), a);
    drain();

    // Backpressure: downstream stalled for the first 5 cycles of an 8-beat stream
    stall_acc = 0;
    stall_left = 5;
    for (int i = 0; i < 8; i++) begin
      m = {1'b1, 23'($urandom)};
      send_m(m, 8'($urandom_range(1, 253)), 1'($urandom), 1'($urandom), 1'($urandom),
             3'($urandom_range(0, 7)), a);
    end
    chk("stall_accepts", stall_acc, 2);
    drain();

    // Throughput: 100 random beats back to back
    outs0 = outs;
    first = 0;
    for (int i = 0; i < 100; i++) begin
      case ($urandom_range(0, 3))
        0: m = '1;
        1: m = {1'b1, 23'($urandom)};
        2: m = 24'($urandom);
        default: m = {1'b1, {21{1'b1}}, 2'($urandom)};
      endcase
      case ($urandom_range(0, 3))
        0: e = 8'hFE;
        1: e = 8'hFF;
        default: e = 8'($urandom);
      endcase
      send_m(m, e, 1'($urandom), 1'($urandom), 1'($urandom), 3'($urandom_range(0, 7)), a);
      if (i == 0) first = a;
    end
    drain();
    chk("throughput_outs", outs - outs0, 100);
    chk("throughput_cycles", last_out_cyc - first, 101);

    // Reset while two beats are in flight
    send_m(24'h812345, 8'h20, 0, 1, 1, 3'd0, a);
    send_m(24'h876543, 8'h21, 1, 1, 0, 3'd4, a);
    @(posedge Clock);
    #1;
    Reset = 0;
    in_valid = 0;
    #1;
    chk("midreset_out_valid", out_valid, 0);
    exq.delete();
    repeat (2) @(negedge Clock);
    Reset = 1;
    #1;
    chk("post_reset_in_ready", in_ready, 1);
    for (int i = 0; i < 4; i++) begin
      idle(1);
      chk("no_stale_beat", out_valid, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
`default_nettype wire
